// File: rtl/song_rom_if.sv
// song_rom_if: read bus between the song sequencer and the external song ROM.
//
// Signals
//   rom_rd    sequencer -> ROM  one-cycle read strobe
//   rom_addr  sequencer -> ROM  entry address, valid while rom_rd is high
//   rom_data  ROM -> sequencer  {dur[11:4], rest[3], note[2:0]}
//
// Handshake: this bus has no ready/backpressure. The ROM samples rom_addr
// on the clock edge where rom_rd is high. It presents the entry on rom_data
// for the whole following cycle. The sequencer reads it in exactly that
// cycle and never issues back-to-back strobes.
//
// Modports: master = sequencer side, slave = ROM side.
interface song_rom_if #(
    parameter int ADDR_W = 7
) ();
    logic              rom_rd;
    logic [ADDR_W-1:0] rom_addr;
    logic [11:0]       rom_data;

    modport master (output rom_rd, output rom_addr, input rom_data);
    modport slave  (input rom_rd, input rom_addr, output rom_data);
endinterface

// File: rtl/song_sequencer.sv
// song_sequencer: chooses whether the note sent to the frequency generator
// comes from the live guitar path or from a stored song.
//
// During song playback, the sequencer fetches entries from an external
// synchronous ROM. It holds each entry for dur ticks of TICK_DIV clocks.
//
// Ports
//   clk, rst_n   system clock, asynchronous active-low reset
//   play_start   pulse: start or restart the song from address 0
//   play_stop    pulse: abort the song (wins over play_start)
//   loop_en      level: wrap to address 0 at song end instead of stopping
//   live_strum   pulse: strum edge, only honoured while idle
//   live_code    live note code from the fret switches
//   rom          song_rom_if master (rom_rd, rom_addr, rom_data)
//   note_code    note to the frequency generator (0=A .. 6=G)
//   note_gate    1 = sound enabled
//   playing      1 whenever the FSM is not idle
//   song_done    one-cycle pulse on a natural (non-looping) song end
module song_sequencer #(
    parameter int TICK_DIV = 250000,
    parameter int ADDR_W   = 7,
    parameter int DEPTH    = 101
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              play_start,
    input  logic              play_stop,
    input  logic              loop_en,
    input  logic              live_strum,
    input  logic [2:0]        live_code,
    song_rom_if.master        rom,
    output logic [2:0]        note_code,
    output logic              note_gate,
    output logic              playing,
    output logic              song_done
);
    localparam int DIV_W = $clog2(TICK_DIV);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(TICK_DIV - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t            state;
    logic [DIV_W-1:0]  div_q;
    logic [7:0]        dur_q;
    logic              rd_q;
    logic [ADDR_W-1:0] addr_q;

    logic [7:0] rom_dur;
    logic       rom_rest;
    logic [2:0] rom_note;
    logic       tick_wrap;
    logic       hold_end;
    logic       song_end;

    assign rom.rom_rd   = rd_q;
    assign rom.rom_addr = addr_q;

    always_comb begin
        rom_dur   = rom.rom_data[11:4];
        rom_rest  = rom.rom_data[3];
        rom_note  = rom.rom_data[2:0];
        tick_wrap = (div_q == DIV_LAST);
        // The last tick of the last duration unit ends the HOLD.
        // dur_q is never 0 in HOLD because WAIT treats dur==0 as the end of the song.
        hold_end  = (state == HOLD) && tick_wrap && (dur_q == 8'd1);
        song_end  = ((state == WAIT) && (rom_dur == 8'd0)) ||
                    (hold_end && (addr_q == LAST_ADDR));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            div_q     <= '0;
            dur_q     <= '0;
            rd_q      <= 1'b0;
            addr_q    <= '0;
            note_code <= 3'd0;
            note_gate <= 1'b0;
            playing   <= 1'b0;
            song_done <= 1'b0;
        end else begin
            song_done <= 1'b0;
            if (play_stop) begin
                state     <= IDLE;
                note_gate <= 1'b0;
                addr_q    <= '0;
                rd_q      <= 1'b0;
                playing   <= 1'b0;
                div_q     <= '0;
                dur_q     <= '0;
            end else if (play_start) begin
                // note_code/note_gate keep sounding until the first new WAIT.
                state   <= FETCH;
                addr_q  <= '0;
                rd_q    <= 1'b1;
                playing <= 1'b1;
            end else if (song_end) begin
                addr_q <= '0;
                if (loop_en) begin
                    state <= FETCH;
                    rd_q  <= 1'b1;
                end else begin
                    state     <= IDLE;
                    rd_q      <= 1'b0;
                    note_gate <= 1'b0;
                    playing   <= 1'b0;
                    song_done <= 1'b1;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (live_strum) begin
                            note_code <= live_code;
                            note_gate <= (live_code != 3'd7);
                        end
                    end
                    FETCH: begin
                        rd_q  <= 1'b0;
                        state <= WAIT;
                    end
                    WAIT: begin
                        // Code 7 has no pitch, so it is treated as silence.
                        note_code <= rom_note;
                        note_gate <= ~rom_rest & (rom_note != 3'd7);
                        dur_q     <= rom_dur;
                        div_q     <= '0;
                        state     <= HOLD;
                    end
                    HOLD: begin
                        if (hold_end) begin
                            div_q  <= '0;
                            addr_q <= addr_q + ADDR_W'(1);
                            rd_q   <= 1'b1;
                            state  <= FETCH;
                        end else if (tick_wrap) begin
                            div_q <= '0;
                            dur_q <= dur_q - 8'd1;
                        end else begin
                            div_q <= div_q + DIV_W'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_song_sequencer.sv
module tb_song_sequencer;
    localparam int TICK_DIV = 4;
    localparam int ADDR_W   = 7;
    localparam int DEPTH    = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       play_start, play_stop, loop_en, live_strum;
    logic [2:0] live_code;
    logic [2:0] note_code;
    logic       note_gate, playing, song_done;

    song_rom_if #(.ADDR_W(ADDR_W)) rom_bus ();

    song_sequencer #(
        .TICK_DIV (TICK_DIV),
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .play_start (play_start),
        .play_stop  (play_stop),
        .loop_en    (loop_en),
        .live_strum (live_strum),
        .live_code  (live_code),
        .rom        (rom_bus),
        .note_code  (note_code),
        .note_gate  (note_gate),
        .playing    (playing),
        .song_done  (song_done)
    );

    // synchronous ROM model: data valid the cycle after rom_rd
    logic [11:0] rom_mem [0:127];
    always @(posedge clk) begin
        if (rom_bus.rom_rd) rom_bus.rom_data <= rom_mem[rom_bus.rom_addr];
    end

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [ADDR_W-1:0] exp_q[$];
    bit sb_en = 1'b0;
    int done_cnt;
    int max_addr;

    typedef struct {
        int         cyc;
        logic       rd;
        logic [6:0] addr;
        logic [2:0] code;
        logic       gate;
        logic       play;
        logic       done;
    } cp_t;
    cp_t tab[$];

    typedef struct {
        logic       strum;
        logic [2:0] code;
        logic       stop;
        logic [2:0] exp_code;
        logic       exp_gate;
    } live_vec_t;
    live_vec_t live_tab[6];

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int c, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc %0d: got %0h expected %0h", name, c, act, exp);
        end
    endtask

    task automatic add_cp(input int c, input logic rd, input logic [6:0] addr, input logic [2:0] code,
                          input logic gate, input logic play, input logic done);
        cp_t e;
        e.cyc = c; e.rd = rd; e.addr = addr; e.code = code;
        e.gate = gate; e.play = play; e.done = done;
        tab.push_back(e);
    endtask

    task automatic chk_all(input string tag, input int c, input logic rd, input logic [6:0] addr,
                           input logic [2:0] code, input logic gate, input logic play, input logic done);
        chk({tag, "_rom_rd"},    c, 16'(rom_bus.rom_rd),   16'(rd));
        chk({tag, "_rom_addr"},  c, 16'(rom_bus.rom_addr), 16'(addr));
        chk({tag, "_note_code"}, c, 16'(note_code),        16'(code));
        chk({tag, "_note_gate"}, c, 16'(note_gate),        16'(gate));
        chk({tag, "_playing"},   c, 16'(playing),          16'(play));
        chk({tag, "_song_done"}, c, 16'(song_done),        16'(done));
    endtask

    // Pulse play_start in cycle 0, then walk ncyc cycles comparing checkpoints.
    task automatic run_song(input string tag, input int ncyc);
        done_cnt = 0;
        max_addr = 0;
        play_start = 1'b1;
        tick();
        play_start = 1'b0;
        for (int c = 1; c <= ncyc; c++) begin
            if (c > 1) tick();
            if (song_done) done_cnt++;
            if (int'(rom_bus.rom_addr) > max_addr) max_addr = int'(rom_bus.rom_addr);
            if (sb_en && rom_bus.rom_rd) begin
                if (exp_q.size() == 0) chk({tag, "_fetch_extra"}, c, 16'(rom_bus.rom_addr), 16'hffff);
                else chk({tag, "_fetch_order"}, c, 16'(rom_bus.rom_addr), 16'(exp_q.pop_front()));
            end
            foreach (tab[i]) begin
                if (tab[i].cyc == c)
                    chk_all(tag, c, tab[i].rd, tab[i].addr, tab[i].code, tab[i].gate, tab[i].play, tab[i].done);
            end
        end
        tab.delete();
    endtask

    task automatic load_song1();
        rom_mem[0] = 12'h032;  // dur 3, note 2
        rom_mem[1] = 12'h02D;  // dur 2, rest, note 5
        rom_mem[2] = 12'h000;  // dur 0: end of song
        rom_mem[3] = 12'h013;
    endtask

    task automatic stop_song();
        play_stop = 1'b1;
        tick();
        play_stop = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        for (int i = 0; i < 128; i++) rom_mem[i] = 12'h000;
        rst_n = 1'b0;
        play_start = 1'b0; play_stop = 1'b0; loop_en = 1'b0;
        live_strum = 1'b0; live_code = 3'd0;
        tick();
        tick();
        chk_all("reset", 0, 1'b0, 7'd0, 3'd0, 1'b0, 1'b0, 1'b0);
        #2 rst_n = 1'b1;
        tick();

        // 1: basic song, natural end
        load_song1();
        add_cp(1,  1'b1, 7'd0, 3'd0, 1'b0, 1'b1, 1'b0);
        add_cp(2,  1'b0, 7'd0, 3'd0, 1'b0, 1'b1, 1'b0);
        add_cp(3,  1'b0, 7'd0, 3'd2, 1'b1, 1'b1, 1'b0);
        add_cp(14, 1'b0, 7'd0, 3'd2, 1'b1, 1'b1, 1'b0);
        add_cp(15, 1'b1, 7'd1, 3'd2, 1'b1, 1'b1, 1'b0);
        add_cp(16, 1'b0, 7'd1, 3'd2, 1'b1, 1'b1, 1'b0);
        add_cp(17, 1'b0, 7'd1, 3'd5, 1'b0, 1'b1, 1'b0);
        add_cp(24, 1'b0, 7'd1, 3'd5, 1'b0, 1'b1, 1'b0);
        add_cp(25, 1'b1, 7'd2, 3'd5, 1'b0, 1'b1, 1'b0);
        add_cp(26, 1'b0, 7'd2, 3'd5, 1'b0, 1'b1, 1'b0);
        add_cp(27, 1'b0, 7'd0, 3'd5, 1'b0, 1'b0, 1'b1);
        add_cp(28, 1'b0, 7'd0, 3'd5, 1'b0, 1'b0, 1'b0);
        run_song("t1", 28);
        chk("t1_done_count", 28, 16'(done_cnt), 16'd1);

        // 2: looping
        loop_en = 1'b1;
        add_cp(1,  1'b1, 7'd0, 3'd5, 1'b0, 1'b1, 1'b0);
        add_cp(3,  1'b0, 7'd0, 3'd2, 1'b1, 1'b1, 1'b0);
        add_cp(26, 1'b0, 7'd2, 3'd5, 1'b0, 1'b1, 1'b0);
        add_cp(27, 1'b1, 7'd0, 3'd5, 1'b0, 1'b1, 1'b0);
        add_cp(28, 1'b0, 7'd0, 3'd5, 1'b0, 1'b1, 1'b0);
        add_cp(29, 1'b0, 7'd0, 3'd2, 1'b1, 1'b1, 1'b0);
        run_song("t2", 40);
        chk("t2_done_count", 40, 16'(done_cnt), 16'd0);
        loop_en = 1'b0;
        stop_song();
        chk("t2_stop_playing", 0, 16'(playing), 16'd0);
        chk("t2_stop_gate", 0, 16'(note_gate), 16'd0);

        // 3: full depth, end after last address
        for (int i = 0; i < 4; i++) rom_mem[i] = 12'h010 | 12'(i);
        for (int i = 0; i < 4; i++) exp_q.push_back(ADDR_W'(i));
        sb_en = 1'b1;
        add_cp(1,  1'b1, 7'd0, 3'd2, 1'b0, 1'b1, 1'b0);
        add_cp(7,  1'b1, 7'd1, 3'd0, 1'b1, 1'b1, 1'b0);
        add_cp(19, 1'b1, 7'd3, 3'd2, 1'b1, 1'b1, 1'b0);
        add_cp(21, 1'b0, 7'd3, 3'd3, 1'b1, 1'b1, 1'b0);
        add_cp(24, 1'b0, 7'd3, 3'd3, 1'b1, 1'b1, 1'b0);
        add_cp(25, 1'b0, 7'd0, 3'd3, 1'b0, 1'b0, 1'b1);
        run_song("t3", 28);
        sb_en = 1'b0;
        chk("t3_fetch_left", 28, 16'(exp_q.size()), 16'd0);
        chk("t3_done_count", 28, 16'(done_cnt), 16'd1);
        chk("t3_max_addr", 28, 16'(max_addr), 16'd3);

        // 4: stop mid-HOLD, then start+stop while idle
        load_song1();
        play_start = 1'b1;
        tick();
        play_start = 1'b0;
        repeat (4) tick();
        chk("t4_in_hold_code", 5, 16'(note_code), 16'd2);
        chk("t4_in_hold_gate", 5, 16'(note_gate), 16'd1);
        play_stop = 1'b1;
        tick();
        play_stop = 1'b0;
        chk("t4_stop_gate", 6, 16'(note_gate), 16'd0);
        chk("t4_stop_playing", 6, 16'(playing), 16'd0);
        chk("t4_stop_addr", 6, 16'(rom_bus.rom_addr), 16'd0);
        chk("t4_stop_rd", 6, 16'(rom_bus.rom_rd), 16'd0);
        chk("t4_stop_done", 6, 16'(song_done), 16'd0);
        done_cnt = 0;
        repeat (3) begin
            tick();
            if (song_done) done_cnt++;
        end
        chk("t4_no_done", 9, 16'(done_cnt), 16'd0);
        play_start = 1'b1;
        play_stop  = 1'b1;
        tick();
        play_start = 1'b0;
        play_stop  = 1'b0;
        chk("t4_both_playing", 1, 16'(playing), 16'd0);
        chk("t4_both_rd", 1, 16'(rom_bus.rom_rd), 16'd0);
        tick();
        chk("t4_both_playing2", 2, 16'(playing), 16'd0);

        // 5: live strums while idle (table), then strum during HOLD
        live_tab[0] = '{1'b1, 3'd5, 1'b0, 3'd5, 1'b1};
        live_tab[1] = '{1'b0, 3'd3, 1'b0, 3'd5, 1'b1};
        live_tab[2] = '{1'b1, 3'd7, 1'b0, 3'd7, 1'b0};
        live_tab[3] = '{1'b1, 3'd1, 1'b0, 3'd1, 1'b1};
        live_tab[4] = '{1'b0, 3'd1, 1'b1, 3'd1, 1'b0};
        live_tab[5] = '{1'b1, 3'd4, 1'b0, 3'd4, 1'b1};
        for (int i = 0; i < 6; i++) begin
            live_strum = live_tab[i].strum;
            live_code  = live_tab[i].code;
            play_stop  = live_tab[i].stop;
            tick();
            live_strum = 1'b0;
            play_stop  = 1'b0;
            chk("t5_live_code", i, 16'(note_code), 16'(live_tab[i].exp_code));
            chk("t5_live_gate", i, 16'(note_gate), 16'(live_tab[i].exp_gate));
        end
        play_start = 1'b1;
        tick();
        play_start = 1'b0;
        chk("t5_hold_prev_code", 1, 16'(note_code), 16'd4);
        tick();
        tick();
        chk("t5_hold_code", 3, 16'(note_code), 16'd2);
        live_strum = 1'b1;
        live_code  = 3'd6;
        tick();
        live_strum = 1'b0;
        chk("t5_strum_ignored_code", 4, 16'(note_code), 16'd2);
        chk("t5_strum_ignored_gate", 4, 16'(note_gate), 16'd1);
        chk("t5_strum_playing", 4, 16'(playing), 16'd1);
        stop_song();

        // 6: asynchronous reset mid-WAIT, then normal restart
        play_start = 1'b1;
        tick();
        play_start = 1'b0;
        tick();
        chk("t6_pre_playing", 2, 16'(playing), 16'd1);
        #2 rst_n = 1'b0;
        #1;
        chk_all("t6_async_rst", 2, 1'b0, 7'd0, 3'd0, 1'b0, 1'b0, 1'b0);
        tick();
        #2 rst_n = 1'b1;
        add_cp(1,  1'b1, 7'd0, 3'd0, 1'b0, 1'b1, 1'b0);
        add_cp(3,  1'b0, 7'd0, 3'd2, 1'b1, 1'b1, 1'b0);
        add_cp(14, 1'b0, 7'd0, 3'd2, 1'b1, 1'b1, 1'b0);
        add_cp(15, 1'b1, 7'd1, 3'd2, 1'b1, 1'b1, 1'b0);
        run_song("t6", 16);
        stop_song();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/song_sequencer.md
Name: song_sequencer

Overview:
- Sequences stored-song playback into the existing frequency generator.
- Arbitrates note control between the live guitar path (strum edge plus fret switches) and a song ROM.
- Fetches note entries from an external synchronous ROM and times each entry with a restartable tick divider.
- Drives a 3-bit note code (0=A … 6=G) and a gate that mutes or unmutes the sound output.

Parameters:
- TICK_DIV, 250000: clk cycles per duration tick (10 ms at 25 MHz); must be ≥2.
- ADDR_W, 7: ROM address width.
- DEPTH, 101: number of valid ROM entries, addresses 0..DEPTH-1; must be ≤2^ADDR_W.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- play_start  in  1  one-cycle pulse: start or restart song
- play_stop  in  1  one-cycle pulse: abort song
- loop_en  in  1  level: repeat song at end
- live_strum  in  1  one-cycle strum edge from the input conditioner
- live_code  in  3  live note code from the fret switches
- rom_rd  out  1  ROM read strobe
- rom_addr  out  ADDR_W  ROM address
- rom_data  in  12  {dur[11:4], rest[3], note[2:0]}, valid the cycle after rom_rd
- note_code  out  3  note to the frequency generator
- note_gate  out  1  1 = sound enabled
- playing  out  1  1 when state ≠ IDLE
- song_done  out  1  one-cycle pulse on natural song end

Behaviour:
- Reset (async, rst_n low), all registered:
  - note_code=0, note_gate=0, playing=0, rom_rd=0, rom_addr=0, song_done=0.
  - State=IDLE; tick divider and duration counter cleared.
  - Reset asserted in any state aborts immediately.
- States: IDLE, FETCH, WAIT, HOLD.
- IDLE:
  - live_strum: next cycle note_code<=live_code, note_gate<=(live_code≠7). Held until the next strum or play_start.
  - play_start: rom_addr<=0, next state FETCH.
  - If live_strum and play_start arrive in the same cycle, play_start wins.
- FETCH (1 cycle): rom_rd=1, rom_addr valid. Next state WAIT.
- WAIT (1 cycle): rom_rd=0; registers rom_data.
  - dur==0: end-of-song.
  - Otherwise: note_code<=note, note_gate<=~rest & (note≠7), duration counter<=dur, tick divider reset to 0, next state HOLD.
- During FETCH/WAIT, note_code and note_gate keep their previous values (no glitch between notes).
- HOLD:
  - Tick divider counts 0..TICK_DIV-1.
  - On wrap, duration counter decrements.
  - HOLD lasts exactly dur×TICK_DIV cycles, then advances:
    - rom_addr==DEPTH-1: end-of-song.
    - Otherwise: rom_addr<=rom_addr+1, FETCH.
- End-of-song (from WAIT or HOLD):
  - loop_en=1: rom_addr<=0, FETCH; no song_done.
  - loop_en=0: song_done=1 for one cycle, note_gate<=0, rom_addr<=0, IDLE. playing falls in the same cycle song_done rises.
- play_stop in any non-IDLE state: next cycle IDLE, note_gate=0, rom_addr=0, rom_rd=0; no song_done. play_stop in IDLE forces note_gate=0.
- play_start in a non-IDLE state: restart at address 0 (FETCH next cycle). Current note_code/note_gate hold until the new WAIT.
- Simultaneous play_start and play_stop: stop wins.
- live_strum in a non-IDLE state: ignored.
- Per-note overhead: exactly 2 cycles (FETCH+WAIT) between HOLD periods.
- Widths: duration counter 8 bits; tick divider sized ceil(log2(TICK_DIV)); no other arithmetic.

Test Plan:
1. TICK_DIV=4; ROM={dur3,note2},{dur2,rest},{dur0}; play_start at cycle 0 ->
   - rom_rd=1, rom_addr=0 at cycle 1.
   - note_code=2, gate=1 at cycles 3-14.
   - FETCH addr1 at cycle 15; gate=0 at cycles 17-24.
   - FETCH addr2 at cycle 25; song_done=1 and playing=0 at cycle 27.
2. Same ROM, loop_en=1 -> after WAIT at addr2, rom_addr=0 FETCH at cycle 27; note_code=2 gate=1 again at cycle 29; song_done never asserts.
3. DEPTH=4, all entries {dur1,note i} -> addresses 0,1,2,3 fetched in order; song_done 1 cycle after the addr3 HOLD ends; rom_addr never reaches 4.
4. play_stop mid-HOLD of entry 0 -> next cycle gate=0, playing=0, rom_addr=0, no song_done. play_start+play_stop in the same cycle while IDLE -> stays IDLE.
5. In IDLE, live_strum with live_code=5 -> next cycle note_code=5, gate=1. live_code=7 strum -> gate=0. Strum during HOLD -> note_code unchanged.
6. rst_n low asynchronously mid-WAIT -> all outputs 0 immediately. After release, play_start restarts from address 0 with normal timing.
